// File: rtl/sram_init_pkg.sv
// sram_init_pkg: shared constants, FSM state type and credit-width helper for the SRAM initiator
package sram_init_pkg;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH = 11;
    typedef enum logic {ST_INIT, ST_RUN} state_t;
    function automatic int cred_w(input int depth);
        return $clog2(depth + 1);
    endfunction
endpackage

// File: rtl/sram_rsp_fifo.sv
// sram_rsp_fifo: response FIFO for captured read data
//   i_clk, i_rst  : clock, synchronous active-high reset (flushes)
//   i_push/i_data : write an entry
//   i_pop         : drop the head entry
//   o_count       : occupancy 0..RSP_DEPTH
//   o_data        : head entry, 0 when empty
module sram_rsp_fifo
    import sram_init_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int RSP_DEPTH  = 4
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           i_push,
    input  logic [DATA_WIDTH-1:0]          i_data,
    input  logic                           i_pop,
    output logic [cred_w(RSP_DEPTH)-1:0]   o_count,
    output logic [DATA_WIDTH-1:0]          o_data
);
    localparam int PW = $clog2(RSP_DEPTH);
    localparam int CW = cred_w(RSP_DEPTH);
    logic [DATA_WIDTH-1:0] r_mem [RSP_DEPTH];
    logic [PW-1:0]         r_wp;
    logic [PW-1:0]         r_rp;
    logic [CW-1:0]         r_cnt;
    // A push while full always coincides with a pop, so the write lands in the slot being vacated
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wp] <= i_data;
                r_wp        <= r_wp + PW'(1);
            end
            if (i_pop) r_rp <= r_rp + PW'(1);
            r_cnt <= r_cnt + CW'(i_push) - CW'(i_pop);
        end
    end
    assign o_count = r_cnt;
    assign o_data  = (r_cnt != '0) ? r_mem[r_rp] : '0;
endmodule

// File: rtl/sram_1rw_initiator.sv
// sram_1rw_initiator: drives a 1RW SRAM macro from a valid/ready request stream, returns read data with credit flow control
//   clk0, rst0                           : clock (also clocks the macro), synchronous active-high reset
//   req_valid/req_ready/req_we/req_addr/req_wdata : request stream (1=write)
//   rsp_valid/rsp_ready/rsp_rdata        : read response stream
//   csb0/web0/addr0/din0                 : registered macro controls (active-low select/write)
//   dout0                                : macro read data, sampled exactly two edges after read acceptance
//   init_done                            : only with SRAM_INIT_EN; high once the zero-fill pass completes
module sram_1rw_initiator
    import sram_init_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int RSP_DEPTH  = 4
) (
    input  logic                  clk0,
    input  logic                  rst0,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  csb0,
    output logic                  web0,
    output logic [ADDR_WIDTH-1:0] addr0,
    output logic [DATA_WIDTH-1:0] din0,
    input  logic [DATA_WIDTH-1:0] dout0
`ifdef SRAM_INIT_EN
    ,
    output logic                  init_done
`endif
);
    localparam int CW = cred_w(RSP_DEPTH);
    logic [CW-1:0] r_cred;
    logic [1:0]    r_rv;
    logic [CW-1:0] w_cnt;
    logic          w_run;
    logic          w_acc;
    logic          w_rd_acc;
    logic          w_pop;
`ifdef SRAM_INIT_EN
    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_iaddr;
    assign w_run     = (r_state == ST_RUN);
    assign init_done = w_run;
`else
    assign w_run = 1'b1;
`endif
    // Writes never need a credit; a read needs a free FIFO slot reserved for its data
    assign req_ready = ~rst0 && w_run && (req_we || r_cred != '0);
    assign w_acc     = req_valid && req_ready;
    assign w_rd_acc  = w_acc && !req_we;
    assign w_pop     = rsp_valid && rsp_ready;
    assign rsp_valid = (w_cnt != '0);
    always_ff @(posedge clk0) begin
        if (rst0) begin
            csb0   <= 1'b1;
            web0   <= 1'b1;
            addr0  <= '0;
            din0   <= '0;
            r_rv   <= '0;
            r_cred <= CW'(RSP_DEPTH);
`ifdef SRAM_INIT_EN
            r_state <= ST_INIT;
            r_iaddr <= '0;
`endif
        end
`ifdef SRAM_INIT_EN
        else if (r_state == ST_INIT) begin
            csb0    <= 1'b0;
            web0    <= 1'b0;
            addr0   <= r_iaddr;
            din0    <= '0;
            r_iaddr <= r_iaddr + ADDR_WIDTH'(1);
            if (&r_iaddr) r_state <= ST_RUN;
        end
`endif
        else begin
            csb0 <= ~w_acc;
            web0 <= ~(w_acc && req_we);
            if (w_acc) begin
                addr0 <= req_addr;
                din0  <= req_wdata;
            end
            // r_rv[1] marks the edge at which the macro output holds this read's data
            r_rv   <= {r_rv[0], w_rd_acc};
            r_cred <= r_cred - CW'(w_rd_acc) + CW'(w_pop);
        end
    end
    sram_rsp_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .RSP_DEPTH  (RSP_DEPTH)
    ) u_fifo (
        .i_clk   (clk0),
        .i_rst   (rst0),
        .i_push  (r_rv[1]),
        .i_data  (dout0),
        .i_pop   (w_pop),
        .o_count (w_cnt),
        .o_data  (rsp_rdata)
    );
endmodule

// File: tb/tb_sram_1rw_initiator.sv
// tb_sram_1rw_initiator: directed and random traffic against a behavioural 1RW macro, scoreboarded read data
module tb_sram_1rw_initiator;
    localparam int DW = 32;
    localparam int AW = 11;
    localparam int RD = 4;
`ifdef SRAM_INIT_EN
    localparam logic [DW-1:0] FILL = 32'hA5A5A5A5;
`else
    localparam logic [DW-1:0] FILL = 32'h0;
`endif
    logic          clk0 = 1'b0;
    logic          rst0 = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_rdata;
    logic          csb0;
    logic          web0;
    logic [AW-1:0] addr0;
    logic [DW-1:0] din0;
    logic [DW-1:0] dout0;
`ifdef SRAM_INIT_EN
    logic          init_done;
`endif
    int            errors = 0;
    int            checks = 0;
    int            ncs = 0;
    bit            rnd = 1'b0;
    logic [DW-1:0] q[$];
    logic [DW-1:0] mem [1<<AW];
    logic [DW-1:0] shadow [1<<AW];

    sram_1rw_initiator #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RSP_DEPTH(RD)) dut (
        .clk0      (clk0),
        .rst0      (rst0),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .csb0      (csb0),
        .web0      (web0),
        .addr0     (addr0),
        .din0      (din0),
        .dout0     (dout0)
`ifdef SRAM_INIT_EN
        ,
        .init_done (init_done)
`endif
    );

    always #5 clk0 = ~clk0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Macro model: controls latched on one cycle are acted on at the following negedge; data goes X just after the next posedge
    initial begin : macro
        logic          p_csb;
        logic          p_web;
        logic [AW-1:0] p_addr;
        logic [DW-1:0] p_din;
        for (int i = 0; i < (1<<AW); i++) mem[i] = FILL;
        p_csb = 1'b1;
        p_web = 1'b1;
        p_addr = '0;
        p_din = '0;
        dout0 = 'x;
        forever begin
            @(negedge clk0);
            if (!p_csb) begin
                if (!p_web) mem[p_addr] = p_din;
                else dout0 = mem[p_addr];
            end
            p_csb = csb0;
            p_web = web0;
            p_addr = addr0;
            p_din = din0;
            if (!csb0) ncs++;
            @(posedge clk0);
            #1 dout0 = 'x;
        end
    end

    always @(negedge clk0) begin
        if (!rst0) chk("outstanding_le_depth", 64'(q.size() <= RD), 64'(1));
        if (rsp_valid && rsp_ready) begin
            chk("rsp_expected", 64'(q.size() != 0), 64'(1));
            if (q.size() != 0) chk("rsp_rdata", 64'(rsp_rdata), 64'(q.pop_front()));
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk0);
            #1;
        end
    endtask

    task automatic op(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        int n = 0;
        req_valid = 1'b1;
        req_we = we;
        req_addr = a;
        req_wdata = d;
        @(negedge clk0);
        while (!req_ready && n < 200) begin
            @(posedge clk0);
            #1;
            if (rnd) rsp_ready = 1'($urandom_range(0, 1));
            n++;
            @(negedge clk0);
        end
        chk("req_accept", 64'(req_ready), 64'(1));
        if (req_ready) begin
            if (we) shadow[a] = d;
            else q.push_back(shadow[a]);
        end
        @(posedge clk0);
        #1;
        req_valid = 1'b0;
        if (rnd) rsp_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic drain();
        int n = 0;
        cyc(1);
        rsp_ready = 1'b1;
        while (q.size() != 0 && n < 100) begin
            cyc(1);
            n++;
        end
        chk("drain_empty", 64'(q.size()), 64'(0));
        cyc(2);
    endtask

    task automatic wait_init();
`ifdef SRAM_INIT_EN
        int n = 0;
        bit rdy_seen = 1'b0;
        @(negedge clk0);
        while (!init_done && n < 2200) begin
            rdy_seen |= req_ready;
            @(negedge clk0);
            n++;
        end
        chk("init_done", 64'(init_done), 64'(1));
        chk("init_cycles", 64'(n), 64'(1<<AW));
        chk("ready_low_in_init", 64'(rdy_seen), 64'(0));
        cyc(1);
`endif
    endtask

    initial begin
        for (int i = 0; i < (1<<AW); i++) shadow[i] = '0;
        cyc(3);
        @(negedge clk0);
        chk("rst_csb0", 64'(csb0), 64'(1));
        chk("rst_web0", 64'(web0), 64'(1));
        chk("rst_addr0", 64'(addr0), 64'(0));
        chk("rst_din0", 64'(din0), 64'(0));
        chk("rst_req_ready", 64'(req_ready), 64'(0));
        chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("rst_rsp_rdata", 64'(rsp_rdata), 64'(0));
`ifdef SRAM_INIT_EN
        chk("rst_init_done", 64'(init_done), 64'(0));
`endif
        @(posedge clk0);
        #1 rst0 = 1'b0;
        wait_init();
`ifdef SRAM_INIT_EN
        op(1'b0, 11'h7FF, '0);
        drain();
`else
        @(negedge clk0);
        chk("ready_after_rst", 64'(req_ready), 64'(1));
        cyc(1);
`endif
        // Write then read the same address on the next cycle
        ncs = 0;
        rsp_ready = 1'b0;
        op(1'b1, 11'h005, 32'hDEADBEEF);
        op(1'b0, 11'h005, '0);
        @(negedge clk0);
        chk("lat_t0", 64'(rsp_valid), 64'(0));
        @(negedge clk0);
        chk("lat_t1", 64'(rsp_valid), 64'(0));
        @(negedge clk0);
        chk("lat_t2", 64'(rsp_valid), 64'(1));
        chk("raw_rdata", 64'(rsp_rdata), 64'(32'hDEADBEEF));
        drain();
        chk("csb_cycles", 64'(ncs), 64'(2));
        // Streaming reads against a stalled consumer
        for (int i = 0; i < 8; i++) op(1'b1, 11'(16 + i), $urandom);
        rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) op(1'b0, 11'(16 + i), '0);
        req_valid = 1'b1;
        req_we = 1'b0;
        req_addr = 11'h014;
        cyc(3);
        @(negedge clk0);
        chk("read_blocked", 64'(req_ready), 64'(0));
        chk("rdata_stable", 64'(rsp_rdata), 64'(q[0]));
        req_valid = 1'b0;
        req_we = 1'b1;
        #1;
        chk("write_no_credit", 64'(req_ready), 64'(1));
        req_we = 1'b0;
        @(posedge clk0);
        #1 rsp_ready = 1'b1;
        for (int i = 4; i < 8; i++) op(1'b0, 11'(16 + i), '0);
        drain();
        // Random mixed traffic with a random consumer
        rnd = 1'b1;
        for (int i = 0; i < 1000; i++) op(1'($urandom_range(0, 1)), 11'($urandom_range(0, 15)), $urandom);
        rnd = 1'b0;
        drain();
        // Pop on the same edge as a capture, with three entries held and one in flight
        rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) op(1'b0, 11'(16 + i), '0);
        cyc(1);
        rsp_ready = 1'b1;
        @(negedge clk0);
        chk("simul_valid", 64'(rsp_valid), 64'(1));
        @(posedge clk0);
        #1 rsp_ready = 1'b0;
        @(negedge clk0);
        chk("simul_head", 64'(rsp_rdata), 64'(q[0]));
        drain();
        // Reset with two reads in flight
        rsp_ready = 1'b0;
        op(1'b0, 11'h010, '0);
        op(1'b0, 11'h011, '0);
        rst0 = 1'b1;
        q.delete();
        cyc(2);
        @(negedge clk0);
        chk("mid_rst_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("mid_rst_csb0", 64'(csb0), 64'(1));
        chk("mid_rst_req_ready", 64'(req_ready), 64'(0));
        @(posedge clk0);
        #1 rst0 = 1'b0;
        wait_init();
        rsp_ready = 1'b1;
        cyc(8);
        @(negedge clk0);
        chk("no_stale_rsp", 64'(rsp_valid), 64'(0));
        cyc(1);
        rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) op(1'b0, 11'(16 + i), '0);
        req_valid = 1'b1;
        req_we = 1'b0;
        @(negedge clk0);
        chk("credits_restored", 64'(req_ready), 64'(0));
        req_valid = 1'b0;
        drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
